radar_trig_frontend: RTL

- Conditions the raw external radar trigger and generates the timing strobes consumed by the azimuth signal generator stage: RADAR_TRIG_PE (trigger positive edge) and USEC_PE (1 µs tick).
- Synchronises and glitch-filters the trigger, applies a re-trigger holdoff, and phase-aligns the µs prescaler to each accepted trigger.
- Measures the trigger period in µs, counts triggers, and flags trigger timeouts for the PS-side status registers.

---
 rtl/radar_sim_pkg.sv | 15 +
 rtl/trig_edge_filter.sv | 45 ++++
 rtl/radar_trig_frontend.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/radar_sim_pkg.sv
// Shared definitions for the radar trigger front end and the azimuth generator benches.
package radar_sim_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_HOLDOFF  = 2'd2,
        ST_RUN      = 2'd3
    } trig_state_e;

    localparam int CLK_PER_USEC_DEF  = 100;
    localparam int MIN_PERIOD_US_DEF = 100;
    localparam int MAX_PERIOD_US_DEF = 10000;

endpackage

// File: rtl/trig_edge_filter.sv
// Synchronises the raw trigger and emits a one-cycle pulse once it has been
// high for MIN_TRIG_HIGH consecutive synchronised cycles.
module trig_edge_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_TRIG_HIGH = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    output logic edge_o
);

    localparam int CW = $clog2(MIN_TRIG_HIGH + 1);
    localparam logic [CW-1:0] HIGH_N    = CW'(MIN_TRIG_HIGH);
    localparam logic [CW-1:0] HIGH_LAST = CW'(MIN_TRIG_HIGH - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   s;
    logic                   edge_q, edge_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Counter saturates at MIN_TRIG_HIGH so the edge fires once per high period.
    always_comb begin
        cnt_d = '0;
        if (s) cnt_d = (cnt_q == HIGH_N) ? cnt_q : cnt_q + 1'b1;
        edge_d = s && (cnt_q == HIGH_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            cnt_q  <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trig_i};
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/radar_trig_frontend.sv
// Radar trigger front end: filtered trigger strobe, phase-aligned µs tick,
// trigger period measurement, trigger count and timeout status.
module radar_trig_frontend
    import radar_sim_pkg::*;
#(
    parameter int CLK_PER_USEC  = CLK_PER_USEC_DEF,
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_TRIG_HIGH = 3,
    parameter int MIN_PERIOD_US = MIN_PERIOD_US_DEF,
    parameter int MAX_PERIOD_US = MAX_PERIOD_US_DEF,
    parameter int PERIOD_W      = 16
) (
    input  logic                SYS_CLK,
    input  logic                SYS_RESETN,
    input  logic                EN,
    input  logic                RADAR_TRIG,
    output logic                RADAR_TRIG_PE,
    output logic                USEC_PE,
    output logic [PERIOD_W-1:0] TRIG_PERIOD_US,
    output logic                TRIG_VALID,
    output logic [31:0]         TRIG_COUNT,
    output logic                TRIG_REJECT,
    output logic                TRIG_TIMEOUT
);

    if (SYNC_STAGES < 2 || MIN_TRIG_HIGH < 1 || CLK_PER_USEC < 2 ||
        MIN_PERIOD_US >= MAX_PERIOD_US || MAX_PERIOD_US >= (2 ** PERIOD_W)) begin : g_bad_params
        $error("radar_trig_frontend: illegal parameter combination");
    end

    localparam int PRE_W = $clog2(CLK_PER_USEC);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(CLK_PER_USEC - 1);
    localparam logic [PERIOD_W-1:0] US_MIN   = PERIOD_W'(MIN_PERIOD_US);
    localparam logic [PERIOD_W-1:0] US_MAX   = PERIOD_W'(MAX_PERIOD_US);

    trig_state_e         state_q, state_d;
    logic [PRE_W-1:0]    presc_q;
    logic                usec_q;
    logic [PERIOD_W-1:0] us_q, us_d;
    logic                trig_pe_q, trig_pe_d;
    logic                reject_q, reject_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;
    logic [31:0]         count_q, count_d;

    logic edge_s, accept, wrap, usec_tick;

    trig_edge_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .MIN_TRIG_HIGH (MIN_TRIG_HIGH)
    ) u_filter (
        .clk_i  (SYS_CLK),
        .rst_ni (SYS_RESETN),
        .trig_i (RADAR_TRIG),
        .edge_o (edge_s)
    );

    assign accept    = edge_s && EN && (state_q == ST_ARMED || state_q == ST_RUN);
    assign wrap      = (presc_q == PRE_LAST);
    // An accepted trigger re-phases the prescaler and takes priority over the wrap tick.
    assign usec_tick = wrap && !accept;

    always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
        if (!SYS_RESETN) begin
            presc_q <= '0;
            usec_q  <= 1'b0;
        end else begin
            presc_q <= (accept || wrap) ? '0 : presc_q + 1'b1;
            usec_q  <= usec_tick;
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
        if (!SYS_RESETN) state_q <= ST_DISABLED;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!EN) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_ARMED;
                ST_ARMED:    if (accept) state_d = ST_HOLDOFF;
                ST_HOLDOFF: begin
                    if (us_q >= US_MAX)      state_d = ST_ARMED;
                    else if (us_q >= US_MIN) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (accept)              state_d = ST_HOLDOFF;
                    else if (us_q >= US_MAX) state_d = ST_ARMED;
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    always_comb begin
        trig_pe_d = 1'b0;
        reject_d  = 1'b0;
        period_d  = period_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        us_d      = us_q;
        if (usec_tick && us_q < US_MAX) us_d = us_q + 1'b1;

        case (state_q)
            ST_DISABLED: begin
                valid_d   = 1'b0;
                timeout_d = 1'b0;
                count_d   = '0;
                us_d      = '0;
            end
            ST_ARMED: begin
                // First trigger after enable or timeout: no period reference yet.
                if (accept) begin
                    trig_pe_d = 1'b1;
                    count_d   = count_q + 32'd1;
                    us_d      = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_HOLDOFF: begin
                if (edge_s) reject_d = 1'b1;
                if (us_q >= US_MAX) begin
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    trig_pe_d = 1'b1;
                    count_d   = count_q + 32'd1;
                    period_d  = us_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    us_d      = '0;
                end else if (us_q >= US_MAX) begin
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                end
            end
            default: ;
        endcase

        if (!EN) begin
            trig_pe_d = 1'b0;
            reject_d  = 1'b0;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
            count_d   = '0;
            us_d      = '0;
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
        if (!SYS_RESETN) begin
            us_q      <= '0;
            trig_pe_q <= 1'b0;
            reject_q  <= 1'b0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            us_q      <= us_d;
            trig_pe_q <= trig_pe_d;
            reject_q  <= reject_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    assign RADAR_TRIG_PE  = trig_pe_q;
    assign USEC_PE        = usec_q;
    assign TRIG_PERIOD_US = period_q;
    assign TRIG_VALID     = valid_q;
    assign TRIG_COUNT     = count_q;
    assign TRIG_REJECT    = reject_q;
    assign TRIG_TIMEOUT   = timeout_q;

endmodule
